// File: rtl/prio_enc_pend.sv
// Registered N-line priority encoder with sticky pending flags.
// Fixed or round-robin selection, valid/ready output port.
module prio_enc_pend #(
  parameter int N          = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int EDGE       = 0,
  parameter int RR         = 0,
  localparam int W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_n,
  input  logic         flush,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] irq_mask,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         any_pend,
  output logic [N-1:0] pend_vec
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W:0]   NW  = (W+1)'(N);

  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] raw_q, raw_d;
  logic [W-1:0] out_code_q, out_code_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0] raw, set, clr, cand;
  logic         hs;
  logic [W-1:0] win;
  logic         found;
  logic [W:0]   idx;
  logic [W:0]   nxt;
  logic [N-1:0] shf;

  // Capture requests into pending; accepted code clears, new set wins
  always_comb begin
    raw   = (ACTIVE_LOW != 0) ? ~req_in : req_in;
    raw_d = raw;
    set   = (EDGE != 0) ? (raw & ~raw_q) : raw;
    if (en_n) set = '0;
    hs    = out_valid_q & out_ready;
    clr   = hs ? (ONE << out_code_q) : '0;
    pend_d = (pend_q & ~clr) | set;
    if (flush) pend_d = '0;
    cand  = pend_q & ~irq_mask & ~clr;
  end

  // Pick the winner among candidates: highest index or round-robin
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    shf   = '0;
    if (RR != 0) begin
      for (int i = 0; i < N; i++) begin
        idx = {1'b0, rr_ptr_q} + (W+1)'(i);
        if (idx >= NW) idx = idx - NW;
        shf = cand >> idx;
        if (!found && shf[0]) begin
          win   = idx[W-1:0];
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        shf = cand >> i;
        if (shf[0]) win = W'(i);
      end
    end
  end

  // Output register loads when free or being accepted; pointer follows grants
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    if (!out_valid_q || out_ready) begin
      if (|cand) begin
        out_code_d  = win;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (flush) out_valid_d = 1'b0;
    nxt = {1'b0, out_code_q} + {{W{1'b0}}, 1'b1};
    if (nxt >= NW) nxt = '0;
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = nxt[W-1:0];
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      raw_q       <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      pend_q      <= pend_d;
      raw_q       <= raw_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign pend_vec  = pend_q;
  assign any_pend  = |(pend_q & ~irq_mask);

endmodule
